// File: rtl/video_line_tap.sv
// video_line_tap: buffers the last LENGTH-1 video lines and emits, for every
// input pixel, a LENGTH-tap vertical column (current line plus the LENGTH-1
// preceding lines at the same column), with a per-tap line-valid mask,
// a frame-stable vertical border mode and sticky line-overflow detection.
// Output latency is exactly two clock cycles.
module video_line_tap #(
    parameter int LENGTH    = 5,
    parameter int DSIZE     = 24,
    parameter int MAX_WIDTH = 2048
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    invs,
    input  logic                    inde,
    input  logic [DSIZE-1:0]        indata,
    input  logic [1:0]              border_mode,
    output logic                    outvs,
    output logic                    outde,
    output logic [DSIZE*LENGTH-1:0] outdata,
    output logic [LENGTH-1:0]       out_line_valid,
    output logic                    err_ovf
);

    localparam int NBUF  = LENGTH - 1;
    localparam int ASIZE = $clog2(MAX_WIDTH);
    localparam int CSIZE = $clog2(MAX_WIDTH + 1);
    localparam int PSIZE = $clog2(NBUF);
    localparam int SW    = PSIZE + 1;
    localparam int LSIZE = $clog2(LENGTH);

    localparam logic [CSIZE-1:0] COL_LIMIT = CSIZE'(MAX_WIDTH);
    localparam logic [PSIZE-1:0] WP_LAST   = PSIZE'(NBUF - 1);
    localparam logic [LSIZE-1:0] LCNT_MAX  = LSIZE'(NBUF);
    localparam logic [SW-1:0]    NBUF_W    = SW'(NBUF);

    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_ZERO = 2'd1,
        MODE_REPL = 2'd2
    } mode_t;

    // Input-side state
    logic             invs_q;
    logic             inde_q;
    logic [CSIZE-1:0] col;
    logic [PSIZE-1:0] wp;
    logic [LSIZE-1:0] line_cnt;
    mode_t            mode_reg;

    // Input-side decode
    logic              vs_rise;
    logic              de_fall;
    logic              pix_ovf;
    logic              wr_en;
    logic [ASIZE-1:0]  addr;
    logic [LENGTH-1:0] cur_mask;

    // Line buffer read data, one word per physical buffer
    logic [NBUF-1:0][DSIZE-1:0] rd_data;

    // First pipeline stage
    logic              vs_s1;
    logic              de_s1;
    logic              ovf_s1;
    logic [DSIZE-1:0]  data_s1;
    logic [LENGTH-1:0] mask_s1;
    logic [LSIZE-1:0]  lcnt_s1;
    logic [PSIZE-1:0]  wp_s1;
    mode_t             mode_s1;

    // Border mux
    logic [LENGTH-1:0][DSIZE-1:0] tap_raw;
    logic [LENGTH-1:0][DSIZE-1:0] tap_out;
    logic [DSIZE-1:0]             oldest;
    logic [SW-1:0]                sel;

    // Edge detection, overflow test, write enable and the per-pixel valid mask
    always_comb begin
        vs_rise  = invs & ~invs_q;
        de_fall  = inde_q & ~inde;
        pix_ovf  = (col >= COL_LIMIT);
        wr_en    = inde & ~pix_ovf;
        addr     = pix_ovf ? '0 : col[ASIZE-1:0];
        cur_mask = '0;
        for (int k = 0; k < LENGTH; k++) begin
            cur_mask[k] = (k == 0) || (!pix_ovf && (LSIZE'(k) <= line_cnt));
        end
    end

    // Column counter, buffer rotation, line count and frame-start bookkeeping
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            invs_q   <= 1'b0;
            inde_q   <= 1'b0;
            col      <= '0;
            wp       <= '0;
            line_cnt <= '0;
            mode_reg <= MODE_ZERO;
        end else begin
            invs_q <= invs;
            inde_q <= inde;
            if (inde) begin
                if (!pix_ovf) begin
                    col <= col + 1'b1;
                end
            end else begin
                col <= '0;
            end
            if (vs_rise) begin
                wp       <= '0;
                line_cnt <= '0;
                mode_reg <= (border_mode == 2'd3) ? MODE_RAW : mode_t'(border_mode);
            end else if (de_fall) begin
                wp <= (wp == WP_LAST) ? '0 : wp + 1'b1;
                if (line_cnt != LCNT_MAX) begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < NBUF; b++) begin : g_buf
        logic [DSIZE-1:0] mem [MAX_WIDTH];
        logic [DSIZE-1:0] rd_q;

        // Read-first line RAM: the oldest tap reads the buffer being overwritten
        always_ff @(posedge clock) begin
            rd_q <= mem[addr];
            if (wr_en && (wp == PSIZE'(b))) begin
                mem[addr] <= indata;
            end
        end

        assign rd_data[b] = rd_q;
    end

    // Stage 1 carries the pixel context alongside the RAM read latency
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vs_s1   <= 1'b0;
            de_s1   <= 1'b0;
            ovf_s1  <= 1'b0;
            data_s1 <= '0;
            mask_s1 <= '0;
            lcnt_s1 <= '0;
            wp_s1   <= '0;
            mode_s1 <= MODE_ZERO;
        end else begin
            vs_s1   <= invs;
            de_s1   <= inde;
            ovf_s1  <= pix_ovf;
            data_s1 <= indata;
            mask_s1 <= cur_mask;
            lcnt_s1 <= line_cnt;
            wp_s1   <= wp;
            mode_s1 <= mode_reg;
        end
    end

    // Map physical buffers onto taps, then apply overflow and border handling
    always_comb begin
        tap_raw    = '0;
        tap_out    = '0;
        sel        = '0;
        tap_raw[0] = data_s1;
        for (int k = 1; k < LENGTH; k++) begin
            sel = {1'b0, wp_s1} + SW'(NBUF - k);
            if (sel >= NBUF_W) begin
                sel = sel - NBUF_W;
            end
            tap_raw[k] = rd_data[sel[PSIZE-1:0]];
        end
        oldest     = tap_raw[lcnt_s1];
        tap_out[0] = data_s1;
        for (int k = 1; k < LENGTH; k++) begin
            if (ovf_s1) begin
                tap_out[k] = '0;
            end else if (mask_s1[k]) begin
                tap_out[k] = tap_raw[k];
            end else begin
                case (mode_s1)
                    MODE_ZERO: tap_out[k] = '0;
                    MODE_REPL: tap_out[k] = oldest;
                    default:   tap_out[k] = tap_raw[k];
                endcase
            end
        end
    end

    // Output register; column data and mask hold while data enable is low
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            outvs          <= 1'b0;
            outde          <= 1'b0;
            outdata        <= '0;
            out_line_valid <= '0;
            err_ovf        <= 1'b0;
        end else begin
            outvs <= vs_s1;
            outde <= de_s1;
            if (de_s1) begin
                outdata        <= tap_out;
                out_line_valid <= mask_s1;
            end
            if (vs_rise) begin
                err_ovf <= 1'b0;
            end else if (de_s1 && ovf_s1) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule
